// File: rtl/shift_add_mult_param_if.sv
// ---------------------------------------------------------------------------
// shift_add_mult_param_if
// Request/response bundle between the command parser, the multiplier and the
// response formatter.
//
// Handshake: the requester holds start high for one cycle together with
// is_signed/src1/src2. The multiplier accepts the request only when busy is
// low, and then captures the operands on that edge. A start seen while busy
// is high is dropped and is not queued. busy stays high from the accepting
// edge through the done cycle. done is a single-cycle pulse, and calc_res is
// valid in that same cycle. calc_res then holds until the next result is
// written.
//
// Signals
//   start      requester -> mult   request strobe
//   is_signed  requester -> mult   1 = two's-complement operands
//   src1       requester -> mult   multiplicand (WIDTH)
//   src2       requester -> mult   multiplier   (WIDTH)
//   busy       mult -> requester   operation in flight
//   done       mult -> requester   result pulse
//   calc_res   mult -> requester   product (2*WIDTH)
// ---------------------------------------------------------------------------
interface shift_add_mult_param_if #(
   parameter int unsigned WIDTH = 16
);
   logic                 start;
   logic                 is_signed;
   logic [WIDTH-1:0]     src1;
   logic [WIDTH-1:0]     src2;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   calc_res;

   modport master (
      output start, is_signed, src1, src2,
      input  busy, done, calc_res
   );

   modport slave (
      input  start, is_signed, src1, src2,
      output busy, done, calc_res
   );
endinterface

// File: rtl/shift_add_mult_param.sv
// ---------------------------------------------------------------------------
// shift_add_mult_param
// Sequential shift-add multiplier with a generic operand width, covering
// signed and unsigned operands. Operands are converted to magnitudes on
// capture. The magnitude product is accumulated one multiplier bit per
// cycle, and the sign is applied in a single final step. The loop exits
// early once the remaining multiplier bits are all zero.
//
// Ports
//   clk          rising-edge clock
//   n_rst        asynchronous active-low reset
//   bus          slave side of shift_add_mult_param_if (start/operands in,
//                busy/done/calc_res out)
//   dbg_state_o  current FSM state (0 IDLE, 1 MUL, 2 SIGN, 3 DONE)
// ---------------------------------------------------------------------------
module shift_add_mult_param #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        n_rst,
   shift_add_mult_param_if.slave       bus,
   output logic [1:0]                  dbg_state_o
);

   localparam int unsigned CW = $clog2(WIDTH);

   localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] ONE_2W    = (2*WIDTH)'(1);
   localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]      CNT_LAST  = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e               state_q,  state_d;
   logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q,    acc_d;
   logic                 neg_q,    neg_d;
   logic [CW-1:0]        cnt_q,    cnt_d;
   logic [2*WIDTH-1:0]   res_q,    res_d;

   logic [WIDTH-1:0]     src1_mag;
   logic [WIDTH-1:0]     src2_mag;

   // The magnitude of the most negative value is 2^(WIDTH-1). This still
   // fits as an unsigned WIDTH-bit value, so no extra bit is needed.
   always_comb begin
      src1_mag = bus.src1;
      src2_mag = bus.src2;
      if (bus.is_signed && bus.src1[WIDTH-1]) begin
         src1_mag = ~bus.src1 + ONE_W;
      end
      if (bus.is_signed && bus.src2[WIDTH-1]) begin
         src2_mag = ~bus.src2 + ONE_W;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= ST_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      res_d    = res_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               mcand_d  = {{WIDTH{1'b0}}, src1_mag};
               mplier_d = src2_mag;
               acc_d    = '0;
               cnt_d    = '0;
               neg_d    = bus.is_signed & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
               state_d  = ST_MUL;
            end
         end

         ST_MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_ONE;
            // Leave as soon as no set multiplier bits remain after this one.
            // The count limit is a backstop that bounds the loop at WIDTH.
            if (((mplier_q >> 1) == '0) || (cnt_q == CNT_LAST)) begin
               state_d = ST_SIGN;
            end
         end

         ST_SIGN: begin
            // This is the only place calc_res is written. It therefore keeps
            // the previous result for the whole of the next operation's MUL
            // phase.
            res_d   = neg_q ? (~acc_q + ONE_2W) : acc_q;
            state_d = ST_DONE;
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.done     = (state_q == ST_DONE);
   assign bus.calc_res = res_q;
   assign dbg_state_o  = state_q;

endmodule

// File: doc/shift_add_mult_param.md
# shift_add_mult_param

Parametrised sequential shift-add multiplier for the UART calculator ALU, the successor to the fixed 16-bit unsigned multiplier. It is generic in operand width and supports signed (two's-complement) and unsigned modes. It terminates early once the remaining multiplier bits are zero, and exposes a start/busy/done handshake. It sits behind the command parser and returns a full-width product to the response formatter.

## Interface
- WIDTH, 16, operand width in bits; legal range 2..32; product width is 2*WIDTH
- clk  in  1  rising-edge clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- src1  in  WIDTH  multiplicand; captured with start
- src2  in  WIDTH  multiplier; captured with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; calc_res is valid in the same cycle
- calc_res  out  2*WIDTH  product; holds its value until the next SIGN state

## Operation
- States: IDLE, MUL, SIGN, DONE.
- Internal registers:
  - mcand (2*WIDTH)
  - mplier (WIDTH)
  - acc (2*WIDTH)
  - neg (1)
  - cnt (ceil(log2 WIDTH) bits)
- IDLE, start=1: capture operands.
  - mcand <= zero-extend(|src1|); mplier <= |src2|; acc <= 0; cnt <= 0.
  - neg <= is_signed & (src1[MSB] ^ src2[MSB]).
  - Go to MUL.
  - Magnitude |x| applies only when is_signed=1 and x[MSB]=1; otherwise the raw bits are used.
  - |most-negative| = 2^(WIDTH-1), which fits unsigned in WIDTH bits, so no overflow is possible.
- MUL, every cycle:
  - If mplier[0], acc <= acc + mcand (2*WIDTH-bit add, carry-out discarded; cannot overflow).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - Go to SIGN when mplier[WIDTH-1:1] == 0 or cnt == WIDTH-1; otherwise stay in MUL.
- SIGN: calc_res <= neg ? (~acc + 1) : acc; go to DONE.
- DONE: done = 1; go to IDLE.
- start is ignored while busy=1; no queuing.
- is_signed, src1 and src2 may change after capture without effect.
- Reset mid-operation: immediate return to IDLE; the operation is discarded and no done is issued.

## Timing
- Reset values: busy=0, done=0, calc_res=0, state=IDLE; internal registers cleared.
- Let k = number of MUL cycles = max(1, index of highest set bit of |src2| + 1); k lies in 1..WIDTH.
- Cycle 0 is the clock edge that samples start=1 in IDLE:
  - busy goes high after that edge.
  - MUL occupies cycles 1..k.
  - SIGN occupies cycle k+1.
  - DONE occupies cycle k+2, with done=1.
- Latency: k+2 cycles; minimum 3 (src2 = 0 or 1), maximum WIDTH+2.
- busy remains high through the DONE cycle and drops on the following edge.
- A start asserted in the DONE cycle is ignored.
- The earliest accepted back-to-back start is the first cycle after DONE, giving throughput of one operation per k+3 cycles.
- calc_res changes only at the edge ending SIGN; it is stable at all other times, including during a new operation's MUL phase.
- done is registered from the state, so it is glitch-free.

## Test plan
- WIDTH=16, unsigned 3 x 5 -> calc_res=0x0000000F; done in cycle 5 (k=3); busy high cycles 1..5.
- Signed -3 (0xFFFD) x 7 -> 0xFFFFFFEB, done in cycle 5. Signed 7 x -3 -> 0xFFFFFFEB, done in cycle 4 (|src2|=3, k=2).
- Unsigned 0xFFFF x 0xFFFF -> 0xFFFE0001, done in cycle 18. Signed 0x8000 x 0x8000 -> 0x40000000, done in cycle 18. Signed 0x8000 x 0x0001 -> 0xFFFF8000, done in cycle 3.
- src2=0, src1=0x1234 -> calc_res=0, done in cycle 3. A second start pulsed during busy and in the DONE cycle -> ignored; exactly one done pulse.
- n_rst asserted in cycle 4 of a 0xFFFF x 0xFFFF operation -> busy=0, done=0, calc_res=0 immediately; no done after release. A new 2 x 2 request then yields 4.
- WIDTH=8, randomized 1000 operands in each mode, compared against a reference product -> all match; done latency equals k+2 every time.
